// File: rtl/disp_hex_mux_n_if.sv
// Host-side bundle for the multiplexed seven-segment driver: digit data and
// display controls in, board pin drive and frame strobe out.
interface disp_hex_mux_n_if #(
    parameter int NDIG = 8
);
    logic [4*NDIG-1:0] hex;
    logic [NDIG-1:0]   dp_in;
    logic [NDIG-1:0]   blank;
    logic              lz_en;
    logic [3:0]        bright;
    logic [NDIG-1:0]   an;
    logic [7:0]        sseg;
    logic              frame_tick;

    modport master (
        output hex, dp_in, blank, lz_en, bright,
        input  an, sseg, frame_tick
    );

    modport slave (
        input  hex, dp_in, blank, lz_en, bright,
        output an, sseg, frame_tick
    );
endinterface

// File: rtl/disp_hex_mux_n.sv
// Time-multiplexed NDIG-digit common-anode seven-segment driver with per-frame
// input snapshot, PWM brightness, blanking and leading-zero suppression.
module disp_hex_mux_n #(
    parameter int NDIG   = 8,
    parameter int SLOT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    disp_hex_mux_n_if.slave  bus
);
    localparam int IDX_W = $clog2(NDIG);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

    logic [SLOT_W-1:0] pre_r;
    logic [IDX_W-1:0]  idx_r;

    logic [4*NDIG-1:0] hex_r;
    logic [NDIG-1:0]   dp_r;
    logic [NDIG-1:0]   blank_r;
    logic              lz_r;
    logic [3:0]        bright_r;

    logic [NDIG-1:0]   an_r;
    logic [7:0]        sseg_r;
    logic              frame_tick_r;

    logic              pre_max_s;
    logic              eof_s;
    logic              zeros_above_s;
    logic [NDIG-1:0]   sup_s;
    logic [3:0]        digit_s;
    logic [3:0]        phase_s;
    logic              on_s;
    logic [NDIG-1:0]   an_next_s;
    logic [7:0]        sseg_next_s;

    // Active-low g..a pattern for one hex nibble.
    function automatic logic [6:0] seg7_decode(input logic [3:0] val);
        logic [6:0] seg;
        case (val)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    assign pre_max_s = &pre_r;
    assign eof_s     = pre_max_s && (idx_r == IDX_LAST);
    assign digit_s   = hex_r[{idx_r, 2'b00} +: 4];
    assign phase_s   = pre_r[SLOT_W-1 -: 4];

    // Suppression scans from the most significant digit down; digit 0 is exempt.
    always_comb begin
        zeros_above_s = 1'b1;
        sup_s         = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            zeros_above_s = zeros_above_s & (hex_r[4*i +: 4] == 4'h0) & ~dp_r[i];
            sup_s[i]      = lz_r & zeros_above_s & (i != 0);
        end
    end

    // Next pin drive for the current slot and PWM phase.
    always_comb begin
        on_s = ~blank_r[idx_r] & ~sup_s[idx_r] & (phase_s <= bright_r);
        if (on_s) begin
            an_next_s   = ~({{(NDIG-1){1'b0}}, 1'b1} << idx_r);
            sseg_next_s = {~dp_r[idx_r], seg7_decode(digit_s)};
        end else begin
            an_next_s   = '1;
            sseg_next_s = 8'hFF;
        end
    end

    // Scan counters, frame snapshot and registered pin outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_r        <= '0;
            idx_r        <= '0;
            hex_r        <= '0;
            dp_r         <= '0;
            blank_r      <= '1;
            lz_r         <= 1'b0;
            bright_r     <= 4'hF;
            an_r         <= '1;
            sseg_r       <= 8'hFF;
            frame_tick_r <= 1'b0;
        end else begin
            pre_r <= pre_r + SLOT_W'(1);
            if (pre_max_s) begin
                if (idx_r == IDX_LAST) begin
                    idx_r <= '0;
                end else begin
                    idx_r <= idx_r + IDX_W'(1);
                end
            end
            if (eof_s) begin
                hex_r    <= bus.hex;
                dp_r     <= bus.dp_in;
                blank_r  <= bus.blank;
                lz_r     <= bus.lz_en;
                bright_r <= bus.bright;
            end
            an_r         <= an_next_s;
            sseg_r       <= sseg_next_s;
            frame_tick_r <= eof_s;
        end
    end

    assign bus.an         = an_r;
    assign bus.sseg       = sseg_r;
    assign bus.frame_tick = frame_tick_r;
endmodule
